// File: rtl/interrupt_redirect_unit_pkg.sv
// interrupt_redirect_unit_pkg: shared types and constants for the fetch-stage interrupt redirect path
//   PC_Path             - fetch PC / vector address type
//   IRQ_NUM             - default number of interrupt lines (index 0 = highest priority)
//   CAUSE_WIDTH         - default cause code width
//   InterruptCausePath  - cause code type
//   InterruptStatePath  - redirect FSM states
package interrupt_redirect_unit_pkg;
   localparam int PC_WIDTH    = 32;
   localparam int IRQ_NUM     = 4;
   localparam int CAUSE_WIDTH = 4;
   typedef logic [PC_WIDTH-1:0] PC_Path;
   typedef logic [CAUSE_WIDTH-1:0] InterruptCausePath;
   typedef enum logic [1:0] {IDLE, PENDING, REDIRECT, HANDLER} InterruptStatePath;
endpackage

// File: rtl/interrupt_redirect_unit_irq_priority_encoder.sv
// irq_priority_encoder: combinational fixed-priority encoder, lowest set index wins
//   req_i   [N-1:0] request vector
//   sel_o   [W-1:0] index of lowest set request (0 when none)
//   valid_o         any request set
module irq_priority_encoder #(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] sel_o,
   output logic         valid_o
);
   assign valid_o = |req_i;
   always_comb begin
      sel_o = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req_i[i]) sel_o = W'(i);
   end
endmodule

// File: rtl/interrupt_redirect_unit.sv
// interrupt_redirect_unit: arbitrates interrupts, waits for a safe point, then pulses a fetch redirect to the handler vector
//   clk, rst          clock, synchronous active-high reset
//   pcOut             current fetch PC, captured as return address
//   irqReq/irqEnable  level requests and per-line enables; globalEnable gates all
//   vecBase/vecMode   trap vector base and direct(0)/vectored(1) mode
//   safePoint         commit allows a redirect this cycle
//   mretValid         mret committed, leaves the handler
//   interruptAddrIn/interruptAddrWE  redirect target and one-cycle strobe
//   trapTaken         one-cycle pulse with interruptAddrWE
//   epcOut/causeOut   captured return PC and cause, held until the next redirect
//   inHandler         high from the redirect cycle until mret
//   irqLatency        (only with RSD_INTERRUPT_LATENCY_COUNT_EN) PENDING cycles of the last taken interrupt
module interrupt_redirect_unit
   import interrupt_redirect_unit_pkg::*;
#(
   parameter int IRQ_NUM     = interrupt_redirect_unit_pkg::IRQ_NUM,
   parameter int CAUSE_WIDTH = interrupt_redirect_unit_pkg::CAUSE_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  PC_Path                 pcOut,
   input  logic [IRQ_NUM-1:0]     irqReq,
   input  logic [IRQ_NUM-1:0]     irqEnable,
   input  logic                   globalEnable,
   input  PC_Path                 vecBase,
   input  logic                   vecMode,
   input  logic                   safePoint,
   input  logic                   mretValid,
   output PC_Path                 interruptAddrIn,
   output logic                   interruptAddrWE,
   output logic                   trapTaken,
   output PC_Path                 epcOut,
   output logic [CAUSE_WIDTH-1:0] causeOut,
   output logic                   inHandler
`ifdef RSD_INTERRUPT_LATENCY_COUNT_EN
   ,
   output logic [15:0]            irqLatency
`endif
);
   InterruptStatePath state_q, state_d;
   logic [IRQ_NUM-1:0] active;
   logic [CAUSE_WIDTH-1:0] sel, cause_q;
   logic valid, take, we_q, trap_q, inh_q;
   PC_Path base, target, addr_q, epc_q;
   assign active = irqReq & irqEnable & {IRQ_NUM{globalEnable}};
   irq_priority_encoder #(.N(IRQ_NUM), .W(CAUSE_WIDTH)) u_enc (
      .req_i  (active),
      .sel_o  (sel),
      .valid_o(valid)
   );
   assign base   = {vecBase[PC_WIDTH-1:2], 2'b00};
   assign target = vecMode ? base + (PC_Path'(sel) << 2) : base;
   // cause is re-evaluated every PENDING cycle; only the safe-point cycle commits it
   assign take   = state_q == PENDING && valid && safePoint;
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     state_d = valid ? PENDING : IDLE;
         PENDING:  state_d = !valid ? IDLE : safePoint ? REDIRECT : PENDING;
         REDIRECT: state_d = HANDLER;
         HANDLER:  state_d = mretValid ? IDLE : HANDLER;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         trap_q  <= 1'b0;
         inh_q   <= 1'b0;
         addr_q  <= '0;
         epc_q   <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= take;
         trap_q  <= take;
         inh_q   <= state_d == REDIRECT || state_d == HANDLER;
         if (take) begin
            addr_q  <= target;
            epc_q   <= pcOut;
            cause_q <= sel;
         end
      end
   end
   assign interruptAddrIn = addr_q;
   assign interruptAddrWE = we_q;
   assign trapTaken       = trap_q;
   assign epcOut          = epc_q;
   assign causeOut        = cause_q;
   assign inHandler       = inh_q;
`ifdef RSD_INTERRUPT_LATENCY_COUNT_EN
   // cnt_q counts PENDING cycles already elapsed; the taking cycle itself adds one
   logic [15:0] cnt_q, lat_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         lat_q <= '0;
      end else begin
         if (state_q == IDLE && valid) cnt_q <= '0;
         else if (state_q == PENDING && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
         if (take) lat_q <= cnt_q == 16'hFFFF ? cnt_q : cnt_q + 16'd1;
      end
   end
   assign irqLatency = lat_q;
`endif
endmodule

// File: tb/tb_interrupt_redirect_unit.sv
// tb_interrupt_redirect_unit: directed self-checking bench for interrupt_redirect_unit
module tb_interrupt_redirect_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pcOut, vecBase, interruptAddrIn, epcOut;
   logic [3:0]  irqReq, irqEnable, causeOut;
   logic        globalEnable, vecMode, safePoint, mretValid;
   logic        interruptAddrWE, trapTaken, inHandler;
`ifdef RSD_INTERRUPT_LATENCY_COUNT_EN
   logic [15:0] irqLatency;
`endif
   int n_checks = 0;
   int n_fails  = 0;

   interrupt_redirect_unit dut (
      .clk            (clk),
      .rst            (rst),
      .pcOut          (pcOut),
      .irqReq         (irqReq),
      .irqEnable      (irqEnable),
      .globalEnable   (globalEnable),
      .vecBase        (vecBase),
      .vecMode        (vecMode),
      .safePoint      (safePoint),
      .mretValid      (mretValid),
      .interruptAddrIn(interruptAddrIn),
      .interruptAddrWE(interruptAddrWE),
      .trapTaken      (trapTaken),
      .epcOut         (epcOut),
      .causeOut       (causeOut),
      .inHandler      (inHandler)
`ifdef RSD_INTERRUPT_LATENCY_COUNT_EN
      ,
      .irqLatency     (irqLatency)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; pcOut = 32'h0; vecBase = 32'h0; irqReq = 4'h0; irqEnable = 4'hF;
      globalEnable = 1'b1; vecMode = 1'b0; safePoint = 1'b0; mretValid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_we", interruptAddrWE, 0);
      check("rst_trap", trapTaken, 0);
      check("rst_inh", inHandler, 0);
      check("rst_addr", interruptAddrIn, 0);
      check("rst_epc", epcOut, 0);
      check("rst_cause", causeOut, 0);
`ifdef RSD_INTERRUPT_LATENCY_COUNT_EN
      check("rst_lat", irqLatency, 0);
`endif
      // direct mode
      vecBase = 32'h8000_1003; vecMode = 1'b0; safePoint = 1'b1; pcOut = 32'h100; irqReq = 4'b0100;
      tick();
      check("dir_we_pend", interruptAddrWE, 0);
      pcOut = 32'h104;
      tick();
      check("dir_we", interruptAddrWE, 1);
      check("dir_trap", trapTaken, 1);
      check("dir_addr", interruptAddrIn, 32'h8000_1000);
      check("dir_cause", causeOut, 2);
      check("dir_epc", epcOut, 32'h104);
      check("dir_inh_redirect", inHandler, 1);
      irqReq = 4'b0000; pcOut = 32'h8000_1000;
      tick();
      check("dir_we_drop", interruptAddrWE, 0);
      check("dir_trap_drop", trapTaken, 0);
      check("dir_inh", inHandler, 1);
      mretValid = 1'b1;
      tick();
      mretValid = 1'b0;
      check("dir_inh_mret", inHandler, 0);
      check("dir_epc_hold", epcOut, 32'h104);
      // vectored priority, masking in handler, re-arbitration after mret
      vecBase = 32'h1000; vecMode = 1'b1; irqReq = 4'b1010; pcOut = 32'h200;
      tick(); tick();
      check("vec_we", interruptAddrWE, 1);
      check("vec_cause", causeOut, 1);
      check("vec_addr", interruptAddrIn, 32'h1004);
      check("vec_epc", epcOut, 32'h200);
      tick();
      check("vec_single_pulse", interruptAddrWE, 0);
      irqReq = 4'b0001;
      tick(); tick(); tick();
      check("mask_we", interruptAddrWE, 0);
      check("mask_inh", inHandler, 1);
      check("mask_cause_hold", causeOut, 1);
      mretValid = 1'b1; pcOut = 32'h300;
      tick();
      mretValid = 1'b0;
      check("remask_idle_we", interruptAddrWE, 0);
      tick();
      check("rearb_pend_we", interruptAddrWE, 0);
      tick();
      check("rearb_we", interruptAddrWE, 1);
      check("rearb_cause", causeOut, 0);
      check("rearb_addr", interruptAddrIn, 32'h1000);
      irqReq = 4'b0000;
      tick();
      mretValid = 1'b1;
      tick();
      mretValid = 1'b0;
      // late higher-priority arrival; stray mret while pending is ignored
      vecBase = 32'h2000; vecMode = 1'b1; safePoint = 1'b0; irqReq = 4'b1000;
      tick();
      tick(); tick();
      irqReq = 4'b1001; mretValid = 1'b1;
      tick();
      mretValid = 1'b0;
      tick();
      check("late_wait_we", interruptAddrWE, 0);
      safePoint = 1'b1; pcOut = 32'h400;
      tick();
      check("late_we", interruptAddrWE, 1);
      check("late_cause", causeOut, 0);
      check("late_addr", interruptAddrIn, 32'h2000);
      check("late_epc", epcOut, 32'h400);
`ifdef RSD_INTERRUPT_LATENCY_COUNT_EN
      check("late_lat", irqLatency, 5);
`endif
      irqReq = 4'b0000;
      tick();
      mretValid = 1'b1;
      tick();
      mretValid = 1'b0;
      // withdrawal before safe point
      safePoint = 1'b0; irqReq = 4'b0010;
      tick();
      irqReq = 4'b0000;
      tick();
      safePoint = 1'b1;
      tick(); tick();
      check("wd_we", interruptAddrWE, 0);
      check("wd_inh", inHandler, 0);
      check("wd_cause_hold", causeOut, 0);
      // global enable drop while pending
      safePoint = 1'b0; irqReq = 4'b0001;
      tick();
      globalEnable = 1'b0; safePoint = 1'b1;
      tick();
      check("ge_we", interruptAddrWE, 0);
      tick();
      check("ge_we2", interruptAddrWE, 0);
      check("ge_inh", inHandler, 0);
      irqReq = 4'b0000; globalEnable = 1'b1;
      tick();
      // reset in the REDIRECT cycle
      vecMode = 1'b0; irqReq = 4'b0100; pcOut = 32'h500;
      tick(); tick();
      check("rr_we", interruptAddrWE, 1);
      rst = 1'b1; irqReq = 4'b0000;
      tick();
      rst = 1'b0;
      check("rr_we_clr", interruptAddrWE, 0);
      check("rr_trap_clr", trapTaken, 0);
      check("rr_inh_clr", inHandler, 0);
      check("rr_epc_clr", epcOut, 0);
      check("rr_addr_clr", interruptAddrIn, 0);
      tick();
      check("rr_idle_we", interruptAddrWE, 0);
      // vector wrap
      vecBase = 32'hFFFF_FFFC; vecMode = 1'b1; safePoint = 1'b1; irqReq = 4'b0100; pcOut = 32'h600;
      tick(); tick();
      check("wrap_we", interruptAddrWE, 1);
      check("wrap_addr", interruptAddrIn, 32'h0000_0004);
      check("wrap_cause", causeOut, 2);
`ifdef RSD_INTERRUPT_LATENCY_COUNT_EN
      check("wrap_lat", irqLatency, 1);
`endif
      irqReq = 4'b0000;
      tick();
      check("wrap_we_drop", interruptAddrWE, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
